bcm_plane_sequencer: RTL and testbench

//  Binary-code-modulation (BCM) scheduler, directly downstream of the per-channel gamma LUT stage.

---
 rtl/bcm_pkg.sv | 33 +++
 rtl/bcm_on_timer.sv | 44 ++++
 rtl/bcm_plane_sequencer.sv | 156 +++++++++++++++
 tb/tb_bcm_plane_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcm_pkg.sv
// Shared types and helpers for the BCM plane sequencer.
//   bcm_state_t : sequencer FSM states
//   plane_t     : bit-plane index at the default configuration (8 planes)
//   row_t       : scan-row index at the default configuration (16 rows)
//   tick_width  : tick counter width covering the longest ON or BLANK period
package bcm_pkg;

  localparam int unsigned PLANES_DEF = 8;
  localparam int unsigned ROWS_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_REQ,
    SHIFT_WAIT,
    BLANK,
    LATCH,
    ON
  } bcm_state_t;

  typedef logic [$clog2(PLANES_DEF)-1:0] plane_t;
  typedef logic [$clog2(ROWS_DEF)-1:0]   row_t;

  // Width needed to hold BASE_TICKS<<(PLANES-1), also covering BLANK_TICKS.
  function automatic int unsigned tick_width(input int unsigned base_ticks,
                                             input int unsigned planes,
                                             input int unsigned blank_ticks);
    int unsigned max_ticks;
    max_ticks = base_ticks << (planes - 1);
    if (blank_ticks > max_ticks) max_ticks = blank_ticks;
    return $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/bcm_on_timer.sv
// Loadable down-counter shared by the BLANK and ON periods.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : load i_load_val this cycle (count = i_load_val next cycle)
//   i_load_val     : period length in clocks, must be >= 1
//   o_expired      : high in the cycle the count equals 1 (last cycle of the period)
module bcm_on_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic         r_expired;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - W'(1);
    end
  end

  // Expired is registered from the next count so it lines up with count==1.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_expired <= (w_cnt_nxt == W'(1));
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/bcm_plane_sequencer.sv
// Binary-code-modulation scheduler: for each row walks the bit planes,
// requests a row shift, blanks, latches, then holds OE for BASE_TICKS<<plane.
// Ports:
//   clk_in, reset_n : clock, synchronous active-low reset
//   enable          : run request (sampled in IDLE and at the end of each ON)
//   shift_done      : shifter finished loading (accepted only while waiting)
//   pixel_gc        : gamma-corrected {r,g,b} of the column being shifted
//   rgb_bit         : {r,g,b} bit of the current plane (combinational)
//   shift_start     : 1-clk shift request for shift_row/plane
//   plane/shift_row : plane and row being shifted
//   row_addr        : row driven onto the panel address lines
//   latch, oe_n     : panel LAT pulse and active-low output enable
//   frame_done      : 1-clk pulse after the last plane of the last row
module bcm_plane_sequencer
  import bcm_pkg::*;
#(
  parameter int unsigned PLANES      = 8,
  parameter int unsigned ROWS        = 16,
  parameter int unsigned BASE_TICKS  = 4,
  parameter int unsigned BLANK_TICKS = 2
) (
  input  logic                      clk_in,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      shift_done,
  input  logic [3*PLANES-1:0]       pixel_gc,
  output logic [2:0]                rgb_bit,
  output logic                      shift_start,
  output logic [$clog2(PLANES)-1:0] plane,
  output logic [$clog2(ROWS)-1:0]   shift_row,
  output logic [$clog2(ROWS)-1:0]   row_addr,
  output logic                      latch,
  output logic                      oe_n,
  output logic                      frame_done
);

  localparam int unsigned PL_W  = $clog2(PLANES);
  localparam int unsigned RW_W  = $clog2(ROWS);
  localparam int unsigned CNT_W = tick_width(BASE_TICKS, PLANES, BLANK_TICKS);

  localparam logic [PL_W-1:0] PLANE_LAST = PL_W'(PLANES - 1);
  localparam logic [RW_W-1:0] ROW_LAST   = RW_W'(ROWS - 1);

  bcm_state_t       r_state;
  bcm_state_t       w_next;
  logic [PL_W-1:0]  r_plane;
  logic [RW_W-1:0]  r_shift_row;
  logic [RW_W-1:0]  r_row_addr;
  logic             r_shift_start;
  logic             r_latch;
  logic             r_oe_n;
  logic             r_frame_done;

  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_on_ticks;
  logic             w_expired;
  logic             w_on_exit;

  logic [PLANES-1:0] w_r;
  logic [PLANES-1:0] w_g;
  logic [PLANES-1:0] w_b;

  // ON period computed at full counter width so the MSB plane never truncates.
  assign w_on_ticks = CNT_W'(BASE_TICKS) << r_plane;
  assign w_on_exit  = (r_state == ON) && w_expired;

  bcm_on_timer #(
    .W (CNT_W)
  ) u_timer (
    .i_clk      (clk_in),
    .i_rst_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expired  (w_expired)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and timer load; shift_done outside SHIFT_WAIT is dropped.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE:       if (enable) w_next = SHIFT_REQ;
      SHIFT_REQ:  w_next = SHIFT_WAIT;
      SHIFT_WAIT: begin
        if (shift_done) begin
          w_next     = BLANK;
          w_load     = 1'b1;
          w_load_val = CNT_W'(BLANK_TICKS);
        end
      end
      BLANK:      if (w_expired) w_next = LATCH;
      LATCH: begin
        w_next     = ON;
        w_load     = 1'b1;
        w_load_val = w_on_ticks;
      end
      ON:         if (w_expired) w_next = enable ? SHIFT_REQ : IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Registered outputs decoded from the next state; plane/row advance at ON exit.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_shift_start <= 1'b0;
      r_latch       <= 1'b0;
      r_oe_n        <= 1'b1;
      r_frame_done  <= 1'b0;
      r_plane       <= '0;
      r_shift_row   <= '0;
      r_row_addr    <= '0;
    end else begin
      r_shift_start <= (w_next == SHIFT_REQ);
      r_latch       <= (w_next == LATCH);
      r_oe_n        <= (w_next != ON);
      r_frame_done  <= 1'b0;
      // Address moves with the latch pulse, while the panel is still blanked.
      if (w_next == LATCH) r_row_addr <= r_shift_row;
      if (w_on_exit) begin
        if (r_plane == PLANE_LAST) begin
          r_plane      <= '0;
          r_shift_row  <= (r_shift_row == ROW_LAST) ? '0 : r_shift_row + RW_W'(1);
          r_frame_done <= (r_shift_row == ROW_LAST);
        end else begin
          r_plane <= r_plane + PL_W'(1);
        end
      end
    end
  end

  // Per-channel slices of the colour word, then pick the current plane's bit.
  assign w_r     = pixel_gc[3*PLANES-1 -: PLANES];
  assign w_g     = pixel_gc[2*PLANES-1 -: PLANES];
  assign w_b     = pixel_gc[PLANES-1:0];
  assign rgb_bit = {w_r[r_plane], w_g[r_plane], w_b[r_plane]};

  assign shift_start = r_shift_start;
  assign plane       = r_plane;
  assign shift_row   = r_shift_row;
  assign row_addr    = r_row_addr;
  assign latch       = r_latch;
  assign oe_n        = r_oe_n;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_bcm_plane_sequencer.sv
// Bench for bcm_plane_sequencer: timeline-based reference model, per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_bcm_plane_sequencer;

  localparam int P  = 4;
  localparam int R  = 4;
  localparam int BT = 2;
  localparam int BL = 1;

  logic         clk_in = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         shift_done;
  logic [3*P-1:0] pixel_gc;
  logic [2:0]   rgb_bit;
  logic         shift_start;
  logic [1:0]   plane;
  logic [1:0]   shift_row;
  logic [1:0]   row_addr;
  logic         latch;
  logic         oe_n;
  logic         frame_done;

  bcm_plane_sequencer #(
    .PLANES      (P),
    .ROWS        (R),
    .BASE_TICKS  (BT),
    .BLANK_TICKS (BL)
  ) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .shift_done  (shift_done),
    .pixel_gc    (pixel_gc),
    .rgb_bit     (rgb_bit),
    .shift_start (shift_start),
    .plane       (plane),
    .shift_row   (shift_row),
    .row_addr    (row_addr),
    .latch       (latch),
    .oe_n        (oe_n),
    .frame_done  (frame_done)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: absolute cycle windows for each scheduled event.
  int m_plane, m_row, m_rowaddr;
  int m_req_at, m_lat_at, m_on_lo, m_on_hi, m_exit, m_frame_at;
  bit m_idle, m_wait;

  task automatic model_reset();
    m_plane = 0; m_row = 0; m_rowaddr = 0;
    m_req_at = -1; m_lat_at = -1; m_on_lo = -1; m_on_hi = -2;
    m_exit = -1; m_frame_at = -1;
    m_idle = 1'b1; m_wait = 1'b0;
  endtask

  // Called at posedge k with the inputs driven during cycle k-1.
  task automatic model_step();
    int k;
    k = cyc;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (k == m_lat_at) m_rowaddr = m_row;
    if (k == m_exit) begin
      if (m_plane == P - 1) begin
        m_plane = 0;
        if (m_row == R - 1) begin
          m_row = 0;
          m_frame_at = k;
        end else begin
          m_row++;
        end
      end else begin
        m_plane++;
      end
      if (enable) begin
        m_req_at = k; m_wait = 1'b1;
      end else begin
        m_idle = 1'b1;
      end
    end else if (m_idle) begin
      if (enable) begin
        m_idle = 1'b0; m_req_at = k; m_wait = 1'b1;
      end
    end else if (m_wait && shift_done && k >= m_req_at + 2) begin
      m_wait   = 1'b0;
      m_lat_at = k + BL;
      m_on_lo  = k + BL + 1;
      m_on_hi  = k + BL + (BT << m_plane);
      m_exit   = m_on_hi + 1;
    end
  endtask

  function automatic int rgb_model(input logic [3*P-1:0] px, input int pl);
    int r, g, b;
    r = px[2*P + pl];
    g = px[P + pl];
    b = px[pl];
    return r * 4 + g * 2 + b;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in);
      cyc++;
      model_step();
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk_in);
      #1;
      if (cyc > 0) begin
        chk("shift_start", shift_start, int'(cyc == m_req_at));
        chk("latch", latch, int'(cyc == m_lat_at));
        chk("oe_n", oe_n, int'(!(cyc >= m_on_lo && cyc <= m_on_hi)));
        chk("frame_done", frame_done, int'(cyc == m_frame_at));
        chk("plane", plane, m_plane);
        chk("shift_row", shift_row, m_row);
        chk("row_addr", row_addr, m_rowaddr);
        chk("rgb_bit", rgb_bit, rgb_model(pixel_gc, m_plane));
      end
    end
  end

  // Shifter model.
  int sd_pend  = 0;
  int sd_delay = 5;
  bit sd_rand  = 1'b0;
  bit sd_spur  = 1'b0;
  bit sd_hs    = 1'b0;

  initial begin
    shift_done = 1'b0;
    forever begin
      @(negedge clk_in);
      shift_done = 1'b0;
      if (sd_pend > 0) begin
        sd_pend--;
        if (sd_pend == 0) shift_done = 1'b1;
      end
      if (sd_spur && $urandom_range(0, 9) == 0) shift_done = 1'b1;
      if (shift_start === 1'b1) begin
        if (sd_hs) begin
          shift_done = 1'b1;
          sd_pend    = 3;
          sd_hs      = 1'b0;
        end else begin
          sd_pend = sd_rand ? int'($urandom_range(1, 6)) : sd_delay;
        end
      end
    end
  end

  // Pixel data changes mid-cycle, away from both clock edges.
  initial begin
    int u;
    pixel_gc = '0;
    forever begin
      @(posedge clk_in);
      #2;
      u = $urandom;
      pixel_gc = u[3*P-1:0];
    end
  end

  // Run monitor: OE-low run lengths, rows, end cycles, frame pulses.
  int runs_len[$];
  int runs_row[$];
  int runs_end[$];
  int frame_cnt     = 0;
  int frame_cyc     = -1;
  int rowchg_on     = 0;
  int latch_on      = 0;
  int latch_gap_bad = 0;

  initial begin
    logic       p_oe, p_latch;
    logic [1:0] p_row;
    int         len, cur_row;
    p_oe = 1'b1; p_latch = 1'b0; p_row = '0; len = 0; cur_row = 0;
    forever begin
      @(negedge clk_in);
      #1;
      if (cyc > 0) begin
        if (oe_n === 1'b0) begin
          if (p_oe) begin
            len = 0;
            cur_row = row_addr;
            if (p_latch !== 1'b1) latch_gap_bad++;
          end else if (row_addr !== p_row) begin
            rowchg_on++;
          end
          if (latch !== 1'b0) latch_on++;
          len++;
        end else if (!p_oe) begin
          runs_len.push_back(len);
          runs_row.push_back(cur_row);
          runs_end.push_back(cyc - 1);
        end
        if (frame_done === 1'b1) begin
          frame_cnt++;
          frame_cyc = cyc;
        end
        p_oe = oe_n; p_latch = latch; p_row = row_addr;
      end
    end
  end

  task automatic sample();
    @(negedge clk_in);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s, l, row_k, n0;
    int exp_len[4];
    logic [2:0] e_rgb;
    exp_len = '{2, 4, 8, 16};
    reset_n = 1'b0;
    enable  = 1'b1;

    // Reset held 3 clocks with enable high.
    repeat (3) sample();
    chk("t1_oe_n", oe_n, 1);
    chk("t1_latch", latch, 0);
    chk("t1_shift_start", shift_start, 0);
    chk("t1_row_addr", row_addr, 0);
    chk("t1_plane", plane, 0);
    reset_n = 1'b1;
    sample();
    chk("t1_first_start", shift_start, 1);
    chk("t1_model_req", m_req_at, cyc);

    // Plane timing and row/frame wrap over 17 planes.
    for (int n = 0; n < 3000 && runs_len.size() < 17; n++) sample();
    chk("t2_runs_seen", int'(runs_len.size() >= 17), 1);
    if (runs_len.size() >= 17) begin
      for (int i = 0; i < 16; i++) begin
        chk("t2_on_len", runs_len[i], exp_len[i % 4]);
        chk("t3_row", runs_row[i], i / 4);
      end
      chk("t3_row_wrap", runs_row[16], 0);
      chk("t3_frame_pos", frame_cyc, runs_end[15] + 1);
    end
    chk("t3_frame_cnt", frame_cnt, 1);

    // shift_done together with shift_start is ignored; the second one counts.
    sd_hs = 1'b1;
    sample();
    for (int n = 0; n < 200 && shift_start !== 1'b1; n++) sample();
    chk("t4_start_seen", shift_start, 1);
    s = cyc;
    for (int n = 0; n < 100 && latch !== 1'b1; n++) sample();
    l = cyc;
    chk("t4_latch_delay", l - s, 5);

    // Enable dropped during plane 2 ON.
    for (int n = 0; n < 500 && !(oe_n === 1'b0 && plane == 2); n++) sample();
    chk("t5_on_p2", int'(oe_n === 1'b0 && plane == 2), 1);
    row_k = shift_row;
    n0 = runs_len.size();
    enable = 1'b0;
    for (int n = 0; n < 100 && oe_n !== 1'b1; n++) sample();
    sample();
    chk("t5_run_closed", int'(runs_len.size() > n0), 1);
    if (runs_len.size() > n0) chk("t5_on_len", runs_len[n0], 8);
    chk("t5_plane", plane, 3);
    chk("t5_row", shift_row, row_k);
    repeat (4) sample();
    chk("t5_idle_oe", oe_n, 1);
    chk("t5_idle_start", shift_start, 0);
    enable = 1'b1;
    sample();
    chk("t5_restart", shift_start, 1);
    chk("t5_restart_plane", plane, 3);
    chk("t5_restart_row", shift_row, row_k);

    // Reset in the third clock of the plane 3 ON period.
    for (int n = 0; n < 500 && !(oe_n === 1'b0 && plane == 3); n++) sample();
    sample();
    sample();
    chk("t6_in_on", oe_n, 0);
    reset_n = 1'b0;
    sample();
    chk("t6_oe_n", oe_n, 1);
    chk("t6_shift_start", shift_start, 0);
    chk("t6_latch", latch, 0);
    chk("t6_frame_done", frame_done, 0);
    chk("t6_plane", plane, 0);
    chk("t6_shift_row", shift_row, 0);
    chk("t6_row_addr", row_addr, 0);
    e_rgb = {pixel_gc[2*P], pixel_gc[P], pixel_gc[0]};
    chk("t6_rgb_p0", rgb_bit, e_rgb);
    repeat (2) sample();
    reset_n = 1'b1;

    // Random traffic: shifter delays, spurious pulses, enable drops, resets.
    sd_rand = 1'b1;
    sd_spur = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      enable  = ($urandom_range(0, 19) != 0);
      reset_n = ($urandom_range(0, 599) != 0);
      sample();
    end
    reset_n = 1'b1;
    repeat (3) sample();

    chk("row_addr_stable_on", rowchg_on, 0);
    chk("latch_during_on", latch_on, 0);
    chk("latch_before_on", latch_gap_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
